inst_mem_loadable: RTL and testbench
====================================

# inst_mem_loadable

Parametrised, field-loadable instruction memory for the NECPU core, replacing the fixed combinational program ROM. After reset it clears every word to NOP, then serves registered instruction fetches to the core. A byte-stream loader port, fed from the host/UART side, can overwrite the program at run time while the core is held.

## Interface
Parameters:
- `INST_W`, 16: instruction width in bits; must be a multiple of 8.
- `ADDR_W`, 8: address width; `DEPTH = 2**ADDR_W` words.
- `NOP_WORD`, 0: clear value; opcode 0 in the top 4 bits, zero fill below.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `fetch_en`  in  1  core fetch request.
- `fetch_addr`  in  ADDR_W  fetch address (core R0/PC).
- `fetch_inst`  out  INST_W  fetched instruction.
- `fetch_valid`  out  1  `fetch_inst` is valid this cycle.
- `core_run`  out  1  core may execute; low during CLEAR and LOAD.
- `ld_start`  in  1  pulse; begins a program load at word 0.
- `ld_byte_valid`  in  1  `ld_byte` is valid this cycle.
- `ld_byte`  in  8  program byte, MSB-first within each word.
- `ld_end`  in  1  pulse; ends the load.
- `ld_busy`  out  1  high in LOAD.
- `ld_count`  out  ADDR_W+1  words written in the current or last load.
- `ld_overflow`  out  1  sticky; a complete word arrived after DEPTH words were already written.

## Operation
- The state machine has three states: CLEAR, RUN, LOAD.
- CLEAR (entered on reset):
  - Writes `NOP_WORD` to address `clr_addr`, then increments `clr_addr`; one word per cycle from 0.
  - After writing DEPTH-1, the next state is RUN.
  - `ld_start` is ignored here.
- RUN:
  - `core_run` = 1.
  - `fetch_en` = 1 on cycle t gives `fetch_valid` = 1 and `fetch_inst` = mem[`fetch_addr`] on t+1.
  - `fetch_en` = 0 gives `fetch_valid` = 0 next cycle; `fetch_inst` holds its last value.
  - `ld_start` causes the transition to LOAD.
- On entry to LOAD:
  - `core_run` = 0 and `ld_busy` = 1.
  - The byte counter, write address, `ld_count` and `ld_overflow` are all cleared.
  - Fetches are ignored and `fetch_valid` = 0.
- In LOAD:
  - Each `ld_byte_valid` shifts `ld_byte` into the packing register, MSB-first.
  - On the INST_W/8-th byte, the word is written to mem[waddr], then waddr and `ld_count` increment.
  - Once `ld_count` = DEPTH, further completed words are dropped and `ld_overflow` is set.
  - `ld_end` returns the state to RUN. Any partial word is discarded and memory is not written.
  - If `ld_byte_valid` and `ld_end` occur in the same cycle, the byte is processed first. If it completes a word, that word is written.
  - `ld_start` in LOAD restarts the load: counters and `ld_overflow` clear and waddr returns to 0. Memory already written is not cleared.
- `ld_count` and `ld_overflow` hold their values in RUN until the next `ld_start`.
- No read/write collision is possible, because fetch is disabled in LOAD and CLEAR.

## Timing
- Reset values:
  - State CLEAR, `clr_addr` = 0.
  - `fetch_valid` = 0, `fetch_inst` = `NOP_WORD`.
  - `core_run` = 0, `ld_busy` = 0, `ld_count` = 0, `ld_overflow` = 0.
- CLEAR lasts exactly DEPTH cycles. `core_run` rises on the cycle after the last clear write.
- Fetch latency is 1 cycle, with back-to-back fetches every cycle.
- `ld_start` sampled on cycle t: `ld_busy` = 1 and `core_run` = 0 from t+1.
- `ld_end` sampled on cycle t: `ld_busy` = 0 and `core_run` = 1 from t+1. A word fetched at t+1 reflects every load write.
- A word write takes effect on the cycle its last byte is sampled; `ld_count` updates the following cycle.
- Reset asserted mid-LOAD or mid-CLEAR:
  - All registers return to their reset values immediately and CLEAR restarts from 0.
  - Memory contents are not reset directly; CLEAR overwrites them.

## Structure
- Shared package `necpu_pkg` holds:
  - The 4-bit opcode constants (NOP..XOR).
  - `NOP_WORD`.
  - The state enum {CLEAR, RUN, LOAD}.
- Sub-module `inst_byte_packer` contains the byte counter and shift register. It outputs `word_valid` and `word`, and provides a synchronous clear used by `ld_start`/`ld_end`.
- The memory array is inferred as a simple dual-port RAM: one write port (clear or load) and one registered read port.

## Test plan
- Reset, then wait: `core_run` stays 0 for exactly 256 cycles (ADDR_W = 8). Fetching address 0x37 afterwards returns 0x0000 with `fetch_valid` one cycle after `fetch_en`.
- Load bytes 0x32,0x00,0x31,0x80 then pulse `ld_end`: `ld_count` = 2, mem[0] = 0x3200, mem[1] = 0x3180, and fetches of addresses 0 and 1 return those words.
- Load 3 bytes then `ld_end`: `ld_count` = 1 and mem[1] is unchanged (partial word discarded).
- Load 257 words (514 bytes): `ld_count` = 256, `ld_overflow` = 1, mem[0] holds word 0, not word 256.
- Send the last byte and `ld_end` in the same cycle: the word is written, `core_run` rises the next cycle, and an immediate fetch returns the new word.
- Assert `rst_n` low mid-LOAD: all outputs take their reset values and CLEAR runs again (256 cycles), after which any address reads 0x0000.

Source files
------------

// File: rtl/necpu_pkg.sv
// Shared NECPU definitions: 4-bit opcodes, the NOP instruction word and the
// instruction-memory controller state encoding.
package necpu_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDI = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_XOR = 4'h6;

   localparam logic [15:0] NOP_WORD = {OP_NOP, 12'h000};

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      RUN   = 2'd1,
      LOAD  = 2'd2
   } mem_state_t;

endpackage

// File: rtl/inst_mem_loadable_if.sv
// Fetch and program-loader bundle between the core/host side (master) and the
// loadable instruction memory (slave).
interface inst_mem_loadable_if #(
   parameter int INST_W = 16,
   parameter int ADDR_W = 8
);
   // Handshake rules: fetch_en in cycle t is answered by fetch_valid/fetch_inst
   // in t+1 while core_run is high, otherwise ignored. ld_byte is consumed in
   // every cycle ld_byte_valid is high during a load; there is no back-pressure.
   // ld_start and ld_end are single-cycle pulses.
   logic              fetch_en;
   logic [ADDR_W-1:0] fetch_addr;
   logic [INST_W-1:0] fetch_inst;
   logic              fetch_valid;
   logic              core_run;
   logic              ld_start;
   logic              ld_byte_valid;
   logic [7:0]        ld_byte;
   logic              ld_end;
   logic              ld_busy;
   logic [ADDR_W:0]   ld_count;
   logic              ld_overflow;

   modport master (
      output fetch_en, fetch_addr, ld_start, ld_byte_valid, ld_byte, ld_end,
      input  fetch_inst, fetch_valid, core_run, ld_busy, ld_count, ld_overflow
   );

   modport slave (
      input  fetch_en, fetch_addr, ld_start, ld_byte_valid, ld_byte, ld_end,
      output fetch_inst, fetch_valid, core_run, ld_busy, ld_count, ld_overflow
   );
endinterface

// File: rtl/inst_byte_packer.sv
// Packs an MSB-first byte stream into instruction words. word/word_valid are
// combinational so a word can be written on the edge its last byte arrives.
module inst_byte_packer #(
   parameter int INST_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              byte_valid,
   input  logic [7:0]        byte_in,
   output logic              word_valid,
   output logic [INST_W-1:0] word
);
   localparam int NB    = INST_W / 8;
   localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NB - 1);

   logic [CNT_W-1:0]  cnt;
   logic [INST_W-1:0] shreg;

   assign word_valid = byte_valid && (cnt == LAST);
   assign word       = (shreg << 8) | INST_W'(byte_in);

   // Clear wins over a same-cycle byte; the caller still sees word_valid for
   // that byte, so a completing byte alongside ld_end is not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         shreg <= '0;
      end else if (clr) begin
         cnt   <= '0;
         shreg <= '0;
      end else if (byte_valid) begin
         shreg <= word;
         cnt   <= word_valid ? '0 : cnt + 1'b1;
      end
   end
endmodule

// File: rtl/inst_mem_loadable.sv
// Field-loadable instruction memory: clears to NOP after reset, serves
// registered fetches in RUN, and accepts a byte-stream program load in LOAD.
module inst_mem_loadable #(
   parameter int                INST_W   = 16,
   parameter int                ADDR_W   = 8,
   parameter logic [INST_W-1:0] NOP_WORD = INST_W'(necpu_pkg::NOP_WORD)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   inst_mem_loadable_if.slave     bus,
   output necpu_pkg::mem_state_t  dbg_state
);
   import necpu_pkg::*;

   localparam int                DEPTH     = 2 ** ADDR_W;
   localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   mem_state_t        state, state_nxt;
   logic [ADDR_W-1:0] clr_addr;
   logic [INST_W-1:0] mem [DEPTH];

   logic              pk_clr, pk_valid, ld_restart;
   logic              word_valid;
   logic [INST_W-1:0] word;
   logic              ld_we, mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [INST_W-1:0] mem_wdata;

   logic [ADDR_W:0]   ld_count_q;
   logic              ld_overflow_q;
   logic              fetch_valid_q;
   logic [INST_W-1:0] fetch_inst_q;

   always_comb begin
      state_nxt  = state;
      pk_clr     = 1'b0;
      pk_valid   = 1'b0;
      ld_restart = 1'b0;
      case (state)
         CLEAR: if (clr_addr == LAST_ADDR) state_nxt = RUN;
         RUN: begin
            if (bus.ld_start) begin
               state_nxt  = LOAD;
               pk_clr     = 1'b1;
               ld_restart = 1'b1;
            end
         end
         LOAD: begin
            if (bus.ld_start) begin
               pk_clr     = 1'b1;
               ld_restart = 1'b1;
            end else begin
               pk_valid = bus.ld_byte_valid;
               if (bus.ld_end) begin
                  state_nxt = RUN;
                  pk_clr    = 1'b1;
               end
            end
         end
         default: state_nxt = CLEAR;
      endcase
   end

   inst_byte_packer #(.INST_W(INST_W)) u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (pk_clr),
      .byte_valid (pk_valid),
      .byte_in    (bus.ld_byte),
      .word_valid (word_valid),
      .word       (word)
   );

   // ld_count doubles as the load write address; at DEPTH the word is dropped.
   assign ld_we     = pk_valid && word_valid && (ld_count_q != DEPTH_CNT);
   assign mem_we    = (state == CLEAR) || ld_we;
   assign mem_waddr = (state == CLEAR) ? clr_addr : ld_count_q[ADDR_W-1:0];
   assign mem_wdata = (state == CLEAR) ? NOP_WORD : word;

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= CLEAR;
         clr_addr      <= '0;
         ld_count_q    <= '0;
         ld_overflow_q <= 1'b0;
         fetch_valid_q <= 1'b0;
         fetch_inst_q  <= NOP_WORD;
      end else begin
         state <= state_nxt;
         if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
         if (ld_restart) begin
            ld_count_q    <= '0;
            ld_overflow_q <= 1'b0;
         end else if (pk_valid && word_valid) begin
            if (ld_count_q == DEPTH_CNT) ld_overflow_q <= 1'b1;
            else                         ld_count_q    <= ld_count_q + 1'b1;
         end
         fetch_valid_q <= (state == RUN) && bus.fetch_en;
         if ((state == RUN) && bus.fetch_en) fetch_inst_q <= mem[bus.fetch_addr];
      end
   end

   assign bus.core_run    = (state == RUN);
   assign bus.ld_busy     = (state == LOAD);
   assign bus.ld_count    = ld_count_q;
   assign bus.ld_overflow = ld_overflow_q;
   assign bus.fetch_valid = fetch_valid_q;
   assign bus.fetch_inst  = fetch_inst_q;
   assign dbg_state       = state;
endmodule

// File: tb/tb_inst_mem_loadable.sv
// Directed bench for inst_mem_loadable: clear timing, loads, overflow,
// same-cycle end, restart and reset during a load.
module tb_inst_mem_loadable;
   logic clk;
   logic rst_n;
   necpu_pkg::mem_state_t dbg_state;

   inst_mem_loadable_if #(.INST_W(16), .ADDR_W(8)) bus ();

   inst_mem_loadable #(.INST_W(16), .ADDR_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---- clock / reset ----
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] exp;
   } fvec_t;

   fvec_t       vec [15];
   logic [15:0] exp_q [$];
   int          n_checks = 0;
   int          n_err    = 0;

   // ---- driver tasks ----
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_fetch_valid"}, 32'(bus.fetch_valid), 32'd0);
      chk({tag, "_fetch_inst"},  32'(bus.fetch_inst),  32'h0000);
      chk({tag, "_core_run"},    32'(bus.core_run),    32'd0);
      chk({tag, "_ld_busy"},     32'(bus.ld_busy),     32'd0);
      chk({tag, "_ld_count"},    32'(bus.ld_count),    32'd0);
      chk({tag, "_ld_overflow"}, 32'(bus.ld_overflow), 32'd0);
      chk({tag, "_state"},       32'(dbg_state),       32'(necpu_pkg::CLEAR));
   endtask

   // Called right after reset release; ld_start is pulsed mid-clear and must be ignored.
   task automatic wait_clear(input string tag);
      int n;
      n = 0;
      while (bus.core_run !== 1'b1 && n < 1000) begin
         bus.ld_start = (n == 5);
         tick();
         n++;
      end
      bus.ld_start = 1'b0;
      chk({tag, "_clear_cycles"}, 32'(n), 32'd256);
   endtask

   task automatic load_start();
      bus.ld_start = 1'b1;
      tick();
      bus.ld_start = 1'b0;
      chk("start_busy", 32'(bus.ld_busy), 32'd1);
      chk("start_run",  32'(bus.core_run), 32'd0);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic with_end);
      bus.ld_byte       = b;
      bus.ld_byte_valid = 1'b1;
      bus.ld_end        = with_end;
      tick();
      bus.ld_byte_valid = 1'b0;
      bus.ld_end        = 1'b0;
   endtask

   task automatic load_end();
      bus.ld_end = 1'b1;
      tick();
      bus.ld_end = 1'b0;
      chk("end_busy", 32'(bus.ld_busy), 32'd0);
      chk("end_run",  32'(bus.core_run), 32'd1);
   endtask

   // Back-to-back fetches over vec[lo..hi], then one idle cycle.
   task automatic fetch_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         bus.fetch_addr = vec[i].addr;
         bus.fetch_en   = 1'b1;
         exp_q.push_back(vec[i].exp);
         tick();
         chk($sformatf("fetch_valid[%0d]", i), 32'(bus.fetch_valid), 32'd1);
         chk($sformatf("fetch_inst[%0d]", i), 32'(bus.fetch_inst), 32'(exp_q.pop_front()));
      end
      bus.fetch_en = 1'b0;
      tick();
      chk("fetch_idle_valid", 32'(bus.fetch_valid), 32'd0);
      chk("fetch_idle_hold",  32'(bus.fetch_inst),  32'(vec[hi].exp));
   endtask

   // ---- stimulus + scoreboard ----
   initial begin
      vec[0]  = '{8'h37, 16'h0000};
      vec[1]  = '{8'h00, 16'h3200};
      vec[2]  = '{8'h01, 16'h3180};
      vec[3]  = '{8'h02, 16'h0000};
      vec[4]  = '{8'h00, 16'hAABB};
      vec[5]  = '{8'h01, 16'h3180};
      vec[6]  = '{8'h00, 16'h1000};
      vec[7]  = '{8'hFF, 16'h10FF};
      vec[8]  = '{8'h80, 16'h1080};
      vec[9]  = '{8'h01, 16'h1001};
      vec[10] = '{8'h00, 16'h5E71};
      vec[11] = '{8'h00, 16'h2233};
      vec[12] = '{8'h01, 16'h1001};
      vec[13] = '{8'h00, 16'h0000};
      vec[14] = '{8'h80, 16'h0000};

      bus.fetch_en      = 1'b0;
      bus.fetch_addr    = '0;
      bus.ld_start      = 1'b0;
      bus.ld_byte_valid = 1'b0;
      bus.ld_byte       = '0;
      bus.ld_end        = 1'b0;

      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk_reset_vals("por");
      tick();
      tick();
      rst_n = 1'b1;
      wait_clear("por");
      fetch_range(0, 0);

      // Two-word load
      load_start();
      send_byte(8'h32, 1'b0);
      send_byte(8'h00, 1'b0);
      chk("count_after_w0", 32'(bus.ld_count), 32'd1);
      send_byte(8'h31, 1'b0);
      send_byte(8'h80, 1'b0);
      load_end();
      chk("count_two", 32'(bus.ld_count), 32'd2);
      fetch_range(1, 3);

      // Partial trailing word discarded
      load_start();
      chk("restart_count", 32'(bus.ld_count), 32'd0);
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      send_byte(8'hCC, 1'b0);
      load_end();
      chk("count_partial", 32'(bus.ld_count), 32'd1);
      fetch_range(4, 5);

      // 257 words: the last one overflows
      load_start();
      for (int w = 0; w <= 256; w++) begin
         logic [15:0] wd;
         wd = 16'h1000 + 16'(w);
         send_byte(wd[15:8], 1'b0);
         send_byte(wd[7:0], 1'b0);
         if (w == 255) begin
            chk("count_full", 32'(bus.ld_count), 32'd256);
            chk("ovf_not_yet", 32'(bus.ld_overflow), 32'd0);
         end
      end
      chk("count_ovf", 32'(bus.ld_count), 32'd256);
      chk("ovf_set", 32'(bus.ld_overflow), 32'd1);
      load_end();
      chk("ovf_hold_run", 32'(bus.ld_overflow), 32'd1);
      fetch_range(6, 9);

      // Last byte and ld_end in the same cycle
      load_start();
      chk("ovf_cleared", 32'(bus.ld_overflow), 32'd0);
      send_byte(8'h5E, 1'b0);
      send_byte(8'h71, 1'b1);
      chk("same_cycle_run",   32'(bus.core_run), 32'd1);
      chk("same_cycle_busy",  32'(bus.ld_busy), 32'd0);
      chk("same_cycle_count", 32'(bus.ld_count), 32'd1);
      fetch_range(10, 10);

      // Restart mid-load; fetch ignored while loading
      load_start();
      bus.fetch_en   = 1'b1;
      bus.fetch_addr = 8'h00;
      send_byte(8'hAB, 1'b0);
      bus.fetch_en = 1'b0;
      chk("load_fetch_ignored", 32'(bus.fetch_valid), 32'd0);
      send_byte(8'hCD, 1'b0);
      send_byte(8'h11, 1'b0);
      chk("pre_restart_count", 32'(bus.ld_count), 32'd1);
      load_start();
      chk("restart_count2", 32'(bus.ld_count), 32'd0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      load_end();
      chk("restart_final_count", 32'(bus.ld_count), 32'd1);
      fetch_range(11, 12);

      // Reset during a load
      load_start();
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b0);
      rst_n = 1'b0;
      #2;
      chk_reset_vals("midload");
      tick();
      rst_n = 1'b1;
      wait_clear("midload");
      fetch_range(13, 14);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
